ft601_bus_emulator: RTL and testbench



---
 rtl/ft601_pkg.sv | 29 ++
 rtl/ft601_bus_emulator_if.sv | 28 ++
 rtl/ft601_sync_fifo.sv | 54 +++++
 rtl/ft601_bus_emulator.sv | 135 +++++++++++++
 tb/tb_ft601_bus_emulator.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ft601_pkg.sv
// Shared types and constants for the FT601 245-synchronous bus emulator.
// Used by the interface, the FIFO wrapper and ft601_bus_emulator.
package ft601_pkg;

    localparam int FT601_DATA_W = 32;
    localparam int FT601_BE_W   = 4;
    localparam int FT601_WORD_W = FT601_DATA_W + FT601_BE_W;

    typedef struct packed {
        logic [FT601_DATA_W-1:0] data;
        logic [FT601_BE_W-1:0]   be;
    } ft601_word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ARM  = 2'd1,
        RD_XFER = 2'd2,
        WR_XFER = 2'd3
    } ft601_emu_state_t;

    function automatic ft601_word_t ft601_pack(input logic [FT601_DATA_W-1:0] data,
                                               input logic [FT601_BE_W-1:0]   be);
        ft601_word_t w;
        w.data = data;
        w.be   = be;
        return w;
    endfunction

endpackage

// File: rtl/ft601_bus_emulator_if.sv
// FT601 245-synchronous FIFO bus between controller (master) and chip side (slave).
// Tristate resolution of the shared data lines is left to the board-level top.
interface ft601_bus_emulator_if;
    import ft601_pkg::*;

    logic                    usb_wren_l;
    logic                    usb_rden_l;
    logic                    usb_outen_l;
    logic                    usb_rst_l;
    logic                    usb_txe;
    logic                    usb_rxf;
    logic [FT601_DATA_W-1:0] bus_din;
    logic [FT601_BE_W-1:0]   be_din;
    logic [FT601_DATA_W-1:0] bus_dout;
    logic [FT601_BE_W-1:0]   be_dout;
    logic                    bus_oe;

    modport master (
        output usb_wren_l, usb_rden_l, usb_outen_l, usb_rst_l, bus_din, be_din,
        input  usb_txe, usb_rxf, bus_dout, be_dout, bus_oe
    );

    modport slave (
        input  usb_wren_l, usb_rden_l, usb_outen_l, usb_rst_l, bus_din, be_din,
        output usb_txe, usb_rxf, bus_dout, be_dout, bus_oe
    );

endinterface

// File: rtl/ft601_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count and sync flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module ft601_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 36
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic                       pop,
    output logic [DATA_W-1:0]          dout,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              empty;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ft601_bus_emulator.sv
// Chip-side model of the FT601 245 synchronous FIFO bus with host stream ports.
// Define FT601_EMU_LOOPBACK_EN to route TX words back into RX instead of the host.
module ft601_bus_emulator
    import ft601_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    ft601_bus_emulator_if.slave     bus,
    input  logic [FT601_DATA_W-1:0] host_wr_data,
    input  logic [FT601_BE_W-1:0]   host_wr_be,
    input  logic                    host_wr_valid,
    output logic                    host_wr_ready,
    output logic [FT601_DATA_W-1:0] host_rd_data,
    output logic [FT601_BE_W-1:0]   host_rd_be,
    output logic                    host_rd_valid,
    input  logic                    host_rd_ready,
    output logic                    err_overrun,
    output logic                    err_underrun,
    output logic                    err_protocol
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    ft601_emu_state_t state, state_nxt;
    ft601_word_t      rx_din, rx_head, tx_head, tx_din;
    logic [CW-1:0]    rx_count, tx_count;
    logic             rx_push, rx_pop, tx_push, tx_pop;
    logic             rx_full, rx_empty, tx_full, tx_empty;
    logic             wr_req, rd_req, oe_req, chip_flush;

    assign wr_req     = !bus.usb_wren_l;
    assign rd_req     = !bus.usb_rden_l;
    assign oe_req     = !bus.usb_outen_l;
    assign chip_flush = !bus.usb_rst_l;

    // Flags come only from registered counts so the controller sees no comb loop.
    assign rx_full  = (rx_count == FULL_CNT);
    assign rx_empty = (rx_count == '0);
    assign tx_full  = (tx_count == FULL_CNT);
    assign tx_empty = (tx_count == '0);

    assign bus.usb_txe  = tx_full;
    assign bus.usb_rxf  = rx_empty;
    assign bus.bus_oe   = oe_req && !wr_req;
    assign bus.bus_dout = rx_empty ? '0 : rx_head.data;
    assign bus.be_dout  = rx_empty ? '0 : rx_head.be;

    assign rx_pop  = rd_req && oe_req && !rx_empty;
    assign tx_push = wr_req && !tx_full;
    assign tx_din  = ft601_pack(bus.bus_din, bus.be_din);

    assign host_wr_ready = !rx_full;
    assign host_rd_data  = tx_empty ? '0 : tx_head.data;
    assign host_rd_be    = tx_empty ? '0 : tx_head.be;

`ifdef FT601_EMU_LOOPBACK_EN
    logic loop_move;
    // Host writer wins; the TX head only moves when the host is not offering a word.
    assign loop_move     = !tx_empty && !rx_full && !host_wr_valid;
    assign rx_push       = (host_wr_valid && !rx_full) || loop_move;
    assign rx_din        = host_wr_valid ? ft601_pack(host_wr_data, host_wr_be) : tx_head;
    assign tx_pop        = loop_move;
    assign host_rd_valid = 1'b0;
`else
    assign rx_push       = host_wr_valid && !rx_full;
    assign rx_din        = ft601_pack(host_wr_data, host_wr_be);
    assign tx_pop        = host_rd_ready && !tx_empty;
    assign host_rd_valid = !tx_empty;
`endif

    ft601_sync_fifo #(.DEPTH(DEPTH), .DATA_W(FT601_WORD_W)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (chip_flush),
        .push  (rx_push),
        .din   (rx_din),
        .pop   (rx_pop),
        .dout  (rx_head),
        .count (rx_count)
    );

    ft601_sync_fifo #(.DEPTH(DEPTH), .DATA_W(FT601_WORD_W)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (chip_flush),
        .push  (tx_push),
        .din   (tx_din),
        .pop   (tx_pop),
        .dout  (tx_head),
        .count (tx_count)
    );

    always_ff @(posedge clk) begin
        if (rst || chip_flush) state <= IDLE;
        else                   state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_req)                state_nxt = WR_XFER;
                else if (oe_req && !rd_req) state_nxt = RD_ARM;
            end
            RD_ARM: begin
                if (!oe_req)     state_nxt = IDLE;
                else if (rd_req) state_nxt = RD_XFER;
            end
            RD_XFER: begin
                if (!oe_req) state_nxt = IDLE;
            end
            WR_XFER: begin
                if (!wr_req) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sticky error flags; a flush in the same cycle beats any new event.
    always_ff @(posedge clk) begin
        if (rst || chip_flush) begin
            err_overrun  <= 1'b0;
            err_underrun <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            if (wr_req && tx_full)           err_overrun  <= 1'b1;
            if (rd_req && oe_req && rx_empty) err_underrun <= 1'b1;
            if ((rd_req && state == IDLE) || (wr_req && oe_req))
                err_protocol <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ft601_bus_emulator.sv
// Self-checking bench for ft601_bus_emulator (DEPTH=16), default and loopback builds.
module tb_ft601_bus_emulator;
    import ft601_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] host_wr_data;
    logic [3:0]  host_wr_be;
    logic        host_wr_valid;
    logic        host_wr_ready;
    logic [31:0] host_rd_data;
    logic [3:0]  host_rd_be;
    logic        host_rd_valid;
    logic        host_rd_ready;
    logic        err_overrun, err_underrun, err_protocol;

    int total = 0;
    int bad   = 0;

    ft601_word_t rx_q[$];
    ft601_word_t tx_q[$];

    typedef struct {
        logic outen_l;
        logic wren_l;
        logic exp_oe;
    } vec_t;
    vec_t vt[4];

    ft601_bus_emulator_if bus();

    ft601_bus_emulator #(.DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .host_wr_data  (host_wr_data),
        .host_wr_be    (host_wr_be),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_rd_data  (host_rd_data),
        .host_rd_be    (host_rd_be),
        .host_rd_valid (host_rd_valid),
        .host_rd_ready (host_rd_ready),
        .err_overrun   (err_overrun),
        .err_underrun  (err_underrun),
        .err_protocol  (err_protocol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus.usb_wren_l  = 1'b1;
        bus.usb_rden_l  = 1'b1;
        bus.usb_outen_l = 1'b1;
        bus.usb_rst_l   = 1'b1;
    endtask

    task automatic chip_flush();
        bus.usb_rst_l = 1'b0;
        tick();
        bus.usb_rst_l = 1'b1;
    endtask

    initial begin
        int drained;
        int w;
        ft601_word_t exp_w;

        bus_idle();
        bus.bus_din   = '0;
        bus.be_din    = '0;
        host_wr_data  = '0;
        host_wr_be    = '0;
        host_wr_valid = 1'b0;
        host_rd_ready = 1'b0;
        rst           = 1'b1;
        tick();
        tick();

        // Reset values
        chk("rst_txe", bus.usb_txe, 1'b0);
        chk("rst_rxf", bus.usb_rxf, 1'b1);
        chk("rst_oe", bus.bus_oe, 1'b0);
        chk("rst_dout", {bus.bus_dout, bus.be_dout}, 36'h0);
        chk("rst_wr_ready", host_wr_ready, 1'b1);
        chk("rst_rd_valid", host_rd_valid, 1'b0);
        chk("rst_errs", {err_overrun, err_underrun, err_protocol}, 3'b000);
        rst = 1'b0;
        tick();

        // Host pushes four words, controller reads them OE-then-RD
        for (int i = 0; i < 4; i++) begin
            host_wr_valid = 1'b1;
            host_wr_data  = 32'hA5A5_0001 + 32'(i);
            host_wr_be    = 4'hF - 4'(i);
            rx_q.push_back(ft601_pack(host_wr_data, host_wr_be));
            tick();
            if (i == 0) begin
                chk("first_rxf", bus.usb_rxf, 1'b0);
                chk("first_dout", bus.bus_dout, 32'hA5A5_0001);
            end
        end
        host_wr_valid = 1'b0;
        bus.usb_outen_l = 1'b0;
        tick();
        chk("rd_oe", bus.bus_oe, 1'b1);
        bus.usb_rden_l = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (rx_q.size() == 0) chk("rx_sb_empty", 1'b1, 1'b0);
            else begin
                exp_w = rx_q.pop_front();
                chk("rd_word", {bus.bus_dout, bus.be_dout}, exp_w);
            end
            tick();
        end
        chk("rd_rxf_after", bus.usb_rxf, 1'b1);
        bus_idle();
        tick();
        chk("rd_errs", {err_overrun, err_underrun, err_protocol}, 3'b000);

`ifndef FT601_EMU_LOOPBACK_EN
        // Fill TX, overrun on the 17th write, host drains all 16
        bus.usb_wren_l = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.bus_din = 32'hC0DE_0000 + 32'(i * 3);
            bus.be_din  = 4'(i);
            tx_q.push_back(ft601_pack(bus.bus_din, bus.be_din));
            tick();
        end
        chk("wr_txe_full", bus.usb_txe, 1'b1);
        bus.bus_din = 32'hDEAD_BEEF;
        tick();
        chk("wr_overrun", err_overrun, 1'b1);
        bus.usb_wren_l = 1'b1;
        tick();
        host_rd_ready = 1'b1;
        drained = 0;
        for (int c = 0; c < 40 && drained < 16; c++) begin
            if (host_rd_valid) begin
                if (tx_q.size() == 0) chk("tx_sb_empty", 1'b1, 1'b0);
                else begin
                    exp_w = tx_q.pop_front();
                    chk("drain_word", {host_rd_data, host_rd_be}, exp_w);
                end
                drained++;
            end
            tick();
        end
        chk("drain_count", 36'(drained), 36'd16);
        chk("drain_valid_after", host_rd_valid, 1'b0);
        host_rd_ready = 1'b0;
        chip_flush();
        #1;
        chk("flush_overrun", err_overrun, 1'b0);
`endif

        // Underrun: OE then RD on an empty RX
        chip_flush();
        bus.usb_outen_l = 1'b0;
        tick();
        bus.usb_rden_l = 1'b0;
        #1;
        chk("und_dout", bus.bus_dout, 32'h0);
        tick();
        chk("und_flag", err_underrun, 1'b1);
        chk("und_proto", err_protocol, 1'b0);
        chk("und_rxf", bus.usb_rxf, 1'b1);
        bus_idle();
        tick();
        chip_flush();

        // Simultaneous write and output enable
        bus.usb_wren_l  = 1'b0;
        bus.usb_outen_l = 1'b0;
        bus.bus_din     = 32'h0BAD_F00D;
        bus.be_din      = 4'h3;
        #1;
        chk("proto_oe", bus.bus_oe, 1'b0);
        tick();
        bus_idle();
        chk("proto_flag", err_protocol, 1'b1);
`ifndef FT601_EMU_LOOPBACK_EN
        chk("proto_pushed", {host_rd_valid, host_rd_data, host_rd_be}, {1'b1, 32'h0BAD_F00D, 4'h3});
`else
        chk("proto_rd_valid", host_rd_valid, 1'b0);
`endif
        tick();

        // Mid-burst usb_rst_l pulse discards everything
        for (int i = 0; i < 3; i++) begin
            host_wr_valid = 1'b1;
            host_wr_data  = 32'h5555_0000 + 32'(i);
            host_wr_be    = 4'hF;
            tick();
        end
        host_wr_valid = 1'b0;
        bus.usb_wren_l = 1'b0;
        bus.bus_din    = 32'h7777_0001;
        tick();
        bus.usb_wren_l  = 1'b1;
        bus.usb_outen_l = 1'b0;
        tick();
        bus.usb_rden_l = 1'b0;
        tick();
        bus.usb_rst_l = 1'b0;
        tick();
        bus_idle();
        #1;
        chk("mrst_rxf", bus.usb_rxf, 1'b1);
        chk("mrst_txe", bus.usb_txe, 1'b0);
        chk("mrst_rd_valid", host_rd_valid, 1'b0);
        chk("mrst_dout", bus.bus_dout, 32'h0);
        chk("mrst_errs", {err_overrun, err_underrun, err_protocol}, 3'b000);

        // Reset via rst while RX holds data
        host_wr_valid = 1'b1;
        host_wr_data  = 32'h1111_2222;
        tick();
        host_wr_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_rxf", bus.usb_rxf, 1'b1);
        tick();

        // Table of strobe combinations for bus_oe
        vt[0] = '{outen_l: 1'b1, wren_l: 1'b1, exp_oe: 1'b0};
        vt[1] = '{outen_l: 1'b0, wren_l: 1'b1, exp_oe: 1'b1};
        vt[2] = '{outen_l: 1'b1, wren_l: 1'b0, exp_oe: 1'b0};
        vt[3] = '{outen_l: 1'b0, wren_l: 1'b0, exp_oe: 1'b0};
        for (int i = 0; i < 4; i++) begin
            bus.usb_outen_l = vt[i].outen_l;
            bus.usb_wren_l  = vt[i].wren_l;
            #1;
            chk($sformatf("vec%0d_oe", i), bus.bus_oe, vt[i].exp_oe);
            tick();
            bus_idle();
            tick();
        end
        chip_flush();

`ifdef FT601_EMU_LOOPBACK_EN
        // Loopback: controller write comes back on the read path
        bus.usb_wren_l = 1'b0;
        bus.bus_din    = 32'h1234_5678;
        bus.be_din     = 4'hF;
        tick();
        bus.usb_wren_l = 1'b1;
        w = 0;
        while (bus.usb_rxf && w < 10) begin
            tick();
            w++;
        end
        chk("lb_rxf", bus.usb_rxf, 1'b0);
        bus.usb_outen_l = 1'b0;
        tick();
        bus.usb_rden_l = 1'b0;
        #1;
        chk("lb_dout", bus.bus_dout, 32'h1234_5678);
        chk("lb_be", bus.be_dout, 4'hF);
        tick();
        bus_idle();
        tick();
`else
        w = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
